// File: rtl/line_window_buffer_if.sv
// Pixel-in / window-out bundle between the raster source, line_window_buffer and the window stage.
interface line_window_buffer_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned KROWS  = 3
);
  logic                    start_frame;
  logic                    de_in;
  logic [DATA_W-1:0]       din;
  logic                    rd_start;
  logic                    row_ready;
  logic                    busy;
  logic                    win_valid;
  logic [ADDR_W-1:0]       win_col;
  logic [KROWS*DATA_W-1:0] win_data;
  logic                    frame_done;
  logic                    ovf_err;

  modport master (
    output start_frame, de_in, din, rd_start,
    input  row_ready, busy, win_valid, win_col, win_data, frame_done, ovf_err
  );

  modport slave (
    input  start_frame, de_in, din, rd_start,
    output row_ready, busy, win_valid, win_col, win_data, frame_done, ovf_err
  );
endinterface

// File: rtl/line_window_buffer.sv
// Round-robin row store replaying KROWS vertically aligned rows as one packed column per cycle.
// Optional zero padding of virtual border rows is enabled by defining LINE_WINDOW_ZERO_PAD_EN.
module line_window_buffer #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned KROWS  = 3,
  parameter int unsigned NBANK  = 4,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                clk,
  input  logic                RESET_N,
  line_window_buffer_if.slave bus
);
`ifdef LINE_WINDOW_ZERO_PAD_EN
  localparam int unsigned PAD   = (KROWS - 1) / 2;
  localparam int unsigned N_OUT = IMG_H;
`else
  localparam int unsigned PAD   = 0;
  localparam int unsigned N_OUT = IMG_H - KROWS + 1;
`endif
  localparam int unsigned CW = ADDR_W + 1;
  localparam int unsigned RW = $clog2(IMG_H + NBANK + KROWS + 1);
  localparam int unsigned BW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int unsigned WW = KROWS * DATA_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     wr_col_q, wr_col_d;
  logic [BW-1:0]     wr_bank_q, wr_bank_d;
  logic [RW-1:0]     wr_row_q, wr_row_d;
  logic [RW-1:0]     out_row_q, out_row_d;
  logic              de_prev_q, de_prev_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] rd_col_q, rd_col_d;
  logic [ADDR_W-1:0] win_col_q, win_col_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              ovf_err_q, ovf_err_d;
  logic              row_ready_q, row_ready_d;
  logic              busy_q, busy_d;
  logic [WW-1:0]     win_data_q, win_data_d;
  logic [RW-1:0]     need_c;
  logic              wr_en_c, de_rise_c, de_fall_c;

  logic [DATA_W-1:0] mem_q [NBANK][2**ADDR_W];

  // Next-state: write accounting, lap protection, read sequencing, frame clear
  always_comb begin
    int                src_row;
    logic [BW-1:0]     src_bank;
    state_d      = state_q;
    wr_col_d     = wr_col_q;
    wr_bank_d    = wr_bank_q;
    wr_row_d     = wr_row_q;
    out_row_d    = out_row_q;
    de_prev_d    = bus.de_in;
    drop_d       = drop_q;
    rd_col_d     = rd_col_q;
    win_col_d    = rd_col_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    ovf_err_d    = ovf_err_q;
    win_data_d   = win_data_q;
    wr_en_c      = 1'b0;
    src_row      = 0;
    src_bank     = '0;
    de_rise_c    = bus.de_in & ~de_prev_q;
    de_fall_c    = ~bus.de_in & de_prev_q;

    // A new row that would overwrite a bank still needed by the reader is dropped whole
    if (de_rise_c) begin
      drop_d = (wr_row_q >= out_row_q + RW'(NBANK - PAD));
      if (drop_d) ovf_err_d = 1'b1;
    end
    if (bus.de_in && !drop_d) begin
      if (wr_col_q < CW'(IMG_W)) begin
        wr_en_c  = 1'b1;
        wr_col_d = wr_col_q + 1'b1;
      end else begin
        ovf_err_d = 1'b1;
      end
    end
    if (de_fall_c && !drop_q) begin
      wr_col_d  = '0;
      wr_bank_d = (wr_bank_q == BW'(NBANK - 1)) ? '0 : wr_bank_q + 1'b1;
      if (wr_row_q < RW'(IMG_H)) wr_row_d = wr_row_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.rd_start && row_ready_q) begin
          state_d  = S_READ;
          rd_col_d = '0;
        end
      end
      S_READ: begin
        win_valid_d = 1'b1;
        // Slice i carries row (out_row+i-PAD); rows outside the image read as zero
        for (int i = 0; i < int'(KROWS); i++) begin
          src_row  = int'(out_row_q) + i - int'(PAD);
          src_bank = BW'((src_row + int'(NBANK)) % int'(NBANK));
          if (src_row >= 0 && src_row < int'(IMG_H))
            win_data_d[i*DATA_W +: DATA_W] = mem_q[src_bank][rd_col_q];
          else
            win_data_d[i*DATA_W +: DATA_W] = '0;
        end
        if (rd_col_q == ADDR_W'(IMG_W - 1)) state_d = S_DRAIN;
        else rd_col_d = rd_col_q + 1'b1;
      end
      S_DRAIN: begin
        state_d      = S_IDLE;
        out_row_d    = out_row_q + 1'b1;
        frame_done_d = (out_row_d == RW'(N_OUT));
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.start_frame) begin
      state_d      = S_IDLE;
      wr_col_d     = '0;
      wr_bank_d    = '0;
      wr_row_d     = '0;
      out_row_d    = '0;
      de_prev_d    = 1'b0;
      drop_d       = 1'b0;
      rd_col_d     = '0;
      win_col_d    = '0;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      ovf_err_d    = 1'b0;
      win_data_d   = '0;
      wr_en_c      = 1'b0;
    end

    need_c = out_row_d + RW'(KROWS - PAD);
    if (need_c > RW'(IMG_H)) need_c = RW'(IMG_H);
    row_ready_d = (state_d == S_IDLE) && (wr_row_d >= need_c) && (out_row_d < RW'(N_OUT));
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      wr_col_q     <= '0;
      wr_bank_q    <= '0;
      wr_row_q     <= '0;
      out_row_q    <= '0;
      de_prev_q    <= 1'b0;
      drop_q       <= 1'b0;
      rd_col_q     <= '0;
      win_col_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_err_q    <= 1'b0;
      row_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      win_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_col_q     <= wr_col_d;
      wr_bank_q    <= wr_bank_d;
      wr_row_q     <= wr_row_d;
      out_row_q    <= out_row_d;
      de_prev_q    <= de_prev_d;
      drop_q       <= drop_d;
      rd_col_q     <= rd_col_d;
      win_col_q    <= win_col_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      ovf_err_q    <= ovf_err_d;
      row_ready_q  <= row_ready_d;
      busy_q       <= busy_d;
      win_data_q   <= win_data_d;
    end
  end

  // Row memories are not reset; contents survive start_frame
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_bank_q][wr_col_q[ADDR_W-1:0]] <= bus.din;
  end

  assign bus.row_ready  = row_ready_q;
  assign bus.busy       = busy_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_col    = win_col_q;
  assign bus.win_data   = win_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.ovf_err    = ovf_err_q;

endmodule
